// File: rtl/mod_sample_arbiter.sv
// Two-source round-robin sample arbiter feeding the AM modulator's FWFT sample port.
// Each grant serves BURST_LEN samples; an idle sample can keep the carrier running when both sources are dry.
module mod_sample_arbiter #(
  parameter int                         BITS_PER_SAMPLE = 8,
  parameter int                         BURST_LEN       = 16,
  parameter int                         FILL_IDLE       = 1,
  parameter logic [BITS_PER_SAMPLE-1:0] IDLE_SAMPLE     = 8'h80
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [BITS_PER_SAMPLE-1:0] src0_sample,
  input  logic                       src0_empty,
  output logic                       src0_read,
  input  logic [BITS_PER_SAMPLE-1:0] src1_sample,
  input  logic                       src1_empty,
  output logic                       src1_read,
  output logic [BITS_PER_SAMPLE-1:0] mod_sample,
  output logic                       mod_empty,
  input  logic                       mod_read,
  output logic [1:0]                 grant,
  output logic [15:0]                underrun_cnt
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SRC0 = 2'b01,
    S_SRC1 = 2'b10
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] burst_cnt;
  logic             last_grant;
  logic             pop;

  // Decision for a source that currently owns the modulator.
  function automatic state_t serve(input logic own_empty, input logic oth_empty,
                                   input state_t own, input state_t oth,
                                   input logic fwd_pop, input logic at_last);
    serve = own;
    if (fwd_pop && at_last) begin
      if (!oth_empty)      serve = oth;
      else if (!own_empty) serve = own;
      else                 serve = S_IDLE;
    end else if (!fwd_pop && own_empty) begin
      serve = oth_empty ? S_IDLE : oth;
    end
  endfunction

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    mod_sample = IDLE_SAMPLE;
    mod_empty  = (FILL_IDLE == 0);
    src0_read  = 1'b0;
    src1_read  = 1'b0;
    unique case (state)
      S_SRC0: begin
        mod_sample = src0_sample;
        mod_empty  = src0_empty;
        src0_read  = mod_read & ~src0_empty;
      end
      S_SRC1: begin
        mod_sample = src1_sample;
        mod_empty  = src1_empty;
        src1_read  = mod_read & ~src1_empty;
      end
      default: ;
    endcase
    pop = (state != S_IDLE) && mod_read && !mod_empty;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (!src0_empty && !src1_empty) state_d = last_grant ? S_SRC0 : S_SRC1;
        else if (!src0_empty)           state_d = S_SRC0;
        else if (!src1_empty)           state_d = S_SRC1;
      end
      S_SRC0:  state_d = serve(src0_empty, src1_empty, S_SRC0, S_SRC1, pop, burst_cnt == LAST);
      S_SRC1:  state_d = serve(src1_empty, src0_empty, S_SRC1, S_SRC0, pop, burst_cnt == LAST);
      default: state_d = S_IDLE;
    endcase
    if (!enable) state_d = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      burst_cnt    <= '0;
      last_grant   <= 1'b1;
      underrun_cnt <= '0;
    end else begin
      state <= state_d;
      if (enable) begin
        if (state_d != state && state_d != S_IDLE) begin
          burst_cnt  <= '0;
          last_grant <= (state_d == S_SRC1);
        end else if (pop) begin
          burst_cnt <= (burst_cnt == LAST) ? '0 : burst_cnt + 1'b1;
        end
        if (state == S_IDLE && FILL_IDLE != 0 && mod_read && underrun_cnt != 16'hFFFF)
          underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end

  assign grant = state;

endmodule

// File: tb/tb_mod_sample_arbiter.sv
// Directed bench for mod_sample_arbiter with BURST_LEN=4, idle fill on.
// Sources are modelled as FWFT queues popped on the DUT's read strobes.
module tb_mod_sample_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] src0_sample, src1_sample, mod_sample;
  logic       src0_empty, src1_empty, src0_read, src1_read;
  logic       mod_empty, mod_read;
  logic [1:0] grant;
  logic [15:0] underrun_cnt;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mod_sample_arbiter #(
    .BITS_PER_SAMPLE(8), .BURST_LEN(4), .FILL_IDLE(1), .IDLE_SAMPLE(8'h80)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .src0_sample(src0_sample), .src0_empty(src0_empty), .src0_read(src0_read),
    .src1_sample(src1_sample), .src1_empty(src1_empty), .src1_read(src1_read),
    .mod_sample(mod_sample), .mod_empty(mod_empty), .mod_read(mod_read),
    .grant(grant), .underrun_cnt(underrun_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    src0_empty  = (q0.size() == 0);
    src0_sample = src0_empty ? 8'h00 : q0[0];
    src1_empty  = (q1.size() == 0);
    src1_sample = src1_empty ? 8'h00 : q1[0];
  endtask

  // One clock: capture pop strobes before the edge, update the source queues after it.
  task automatic tick();
    logic r0, r1;
    #1;
    r0 = src0_read;
    r1 = src1_read;
    @(posedge clk);
    #1;
    if (r0 && q0.size() != 0) void'(q0.pop_front());
    if (r1 && q1.size() != 0) void'(q1.pop_front());
    drive_src();
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] exp2[4];
    logic [1:0] exp_g;
    logic [7:0] exp_s;
    int blk;

    rst = 1'b0; enable = 1'b1; mod_read = 1'b0;
    drive_src();
    #2;
    check("rst_grant", grant, 2'b00);
    check("rst_sample", mod_sample, 8'h80);
    check("rst_empty", mod_empty, 1'b0);
    check("rst_reads", {src0_read, src1_read}, 2'b00);
    check("rst_underrun", underrun_cnt, 16'd0);
    #10 rst = 1'b1;

    // Idle fill: three reads count three underruns.
    mod_read = 1'b1;
    repeat (3) tick();
    mod_read = 1'b0;
    #1;
    check("idle_underrun3", underrun_cnt, 16'd3);
    check("idle_grant", grant, 2'b00);

    // Single source burst.
    exp2 = '{8'h03, 8'h05, 8'h00, 8'h0F};
    for (int i = 0; i < 4; i++) q0.push_back(exp2[i]);
    drive_src();
    #1;
    check("s0_grant_same_cycle", grant, 2'b00);
    tick();
    check("s0_grant", grant, 2'b01);
    for (int i = 0; i < 4; i++) begin
      mod_read = 1'b1;
      #1;
      check("s0_sample", mod_sample, exp2[i]);
      check("s0_read", src0_read, 1'b1);
      tick();
    end
    mod_read = 1'b0;
    #1;
    check("s0_drained_grant", grant, 2'b01);
    check("s0_drained_empty", mod_empty, 1'b1);
    tick();
    check("s0_back_idle", grant, 2'b00);
    check("s0_idle_sample", mod_sample, 8'h80);
    check("s0_underrun_hold", underrun_cnt, 16'd3);

    // Both sources always ready: alternating bursts of four, src0 first.
    pulse_reset();
    for (int i = 0; i < 12; i++) begin
      q0.push_back(8'(8'h10 + i));
      q1.push_back(8'(8'h20 + i));
    end
    drive_src();
    tick();
    check("rr_first_grant", grant, 2'b01);
    mod_read = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      blk   = i / 4;
      exp_g = (blk % 2 == 0) ? 2'b01 : 2'b10;
      exp_s = 8'(((blk % 2 == 0) ? 8'h10 : 8'h20) + (blk / 2) * 4 + i % 4);
      check("rr_grant", grant, exp_g);
      check("rr_sample", mod_sample, exp_s);
      tick();
    end
    mod_read = 1'b0;
    #1;
    check("rr_src0_left", q0.size(), 4);
    check("rr_src1_left", q1.size(), 4);

    // src1 runs dry after two pops while src0 waits.
    q0.delete(); q1.delete();
    pulse_reset();
    q1.push_back(8'hA1); q1.push_back(8'hA2);
    drive_src();
    tick();
    check("dry_grant1", grant, 2'b10);
    for (int i = 0; i < 6; i++) q0.push_back(8'(8'hB0 + i));
    drive_src();
    mod_read = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("dry_s1_sample", mod_sample, 8'(8'hA1 + i));
      check("dry_s1_read", src1_read, 1'b1);
      tick();
    end
    #1;
    check("dry_no_s1_read", src1_read, 1'b0);
    check("dry_no_s0_read", src0_read, 1'b0);
    check("dry_mod_empty", mod_empty, 1'b1);
    tick();
    check("dry_switch", grant, 2'b01);
    q1.push_back(8'hC0); q1.push_back(8'hC1); q1.push_back(8'hC2);
    drive_src();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("dry_s0_grant", grant, 2'b01);
      check("dry_s0_sample", mod_sample, 8'(8'hB0 + i));
      tick();
    end
    check("dry_full_burst_switch", grant, 2'b10);
    check("dry_s1_head", mod_sample, 8'hC0);

    // Enable dropped mid-burst, then re-enabled with both sources ready.
    #1;
    check("en_pop_s1", src1_read, 1'b1);
    tick();
    enable = 1'b0; mod_read = 1'b0;
    tick();
    check("en_off_grant", grant, 2'b00);
    mod_read = 1'b1;
    #1;
    check("en_off_reads", {src0_read, src1_read}, 2'b00);
    check("en_off_sample", mod_sample, 8'h80);
    tick();
    check("en_off_underrun_hold", underrun_cnt, 16'd0);
    mod_read = 1'b0;
    enable = 1'b1;
    tick();
    check("en_on_grant", grant, 2'b01);

    // Saturating underrun counter, then async reset mid-burst.
    q0.delete(); q1.delete();
    drive_src();
    tick();
    check("sat_idle", grant, 2'b00);
    mod_read = 1'b1;
    repeat (65540) tick();
    mod_read = 1'b0;
    #1;
    check("sat_underrun", underrun_cnt, 16'hFFFF);
    q0.push_back(8'hD0); q0.push_back(8'hD1);
    drive_src();
    tick();
    check("ar_grant", grant, 2'b01);
    mod_read = 1'b1;
    #1;
    check("ar_pending_read", src0_read, 1'b1);
    rst = 1'b0;
    #1;
    check("ar_grant_cleared", grant, 2'b00);
    check("ar_underrun_cleared", underrun_cnt, 16'd0);
    check("ar_read_dropped", src0_read, 1'b0);
    check("ar_sample", mod_sample, 8'h80);
    mod_read = 1'b0;
    #2 rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
